// File: rtl/inst_encoder_pkg.sv
// Shared RV32I opcode constants, encoding formats and stage-1 payload for the instruction encoder.
// Format decode and immediate range checks live here so any stage can reuse them.
package inst_encoder_pkg;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpRType  = 7'b0110011;

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [2:0] {
        FmtR,
        FmtI,
        FmtS,
        FmtB,
        FmtU,
        FmtJ,
        FmtBad
    } fmt_e;

    typedef struct packed {
        fmt_e        fmt;
        logic        err;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } s1_t;

    function automatic fmt_e decode_fmt(input logic [6:0] op);
        fmt_e fmt;
        case (op)
            OpRType:                 fmt = FmtR;
            OpIType, OpJalr, OpLoad: fmt = FmtI;
            OpStore:                 fmt = FmtS;
            OpBranch:                fmt = FmtB;
            OpLui, OpAuipc:          fmt = FmtU;
            OpJal:                   fmt = FmtJ;
            default:                 fmt = FmtBad;
        endcase
        return fmt;
    endfunction

    // A signed value fits in N bits when every bit from N-1 upward matches the sign bit.
    function automatic logic range_err(input fmt_e fmt, input logic [31:0] imm);
        logic err;
        case (fmt)
            FmtI, FmtS: err = (imm[31:11] != {21{imm[31]}});
            FmtB:       err = (imm[31:12] != {20{imm[31]}}) || imm[0];
            FmtJ:       err = (imm[31:20] != {12{imm[31]}}) || imm[0];
            FmtU:       err = (imm[11:0] != 12'h000);
            FmtR:       err = 1'b0;
            default:    err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle of the instruction encoder: field inputs with valid/ready, and the
// encoded word with its address and error flag.
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );

endinterface

// File: rtl/inst_encoder_imm_pack.sv
// Combinational packer: scatters register, function and immediate fields into an RV32I word
// for the given format. No range checking; out-of-range immediates are simply truncated.
module inst_encoder_imm_pack
    import inst_encoder_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o
);

    always_comb begin
        instr_o = NopInstr;
        unique case (fmt_i)
            FmtR: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FmtI: instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FmtS: instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FmtB: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], opcode_i};
            FmtU: instr_o = {imm_i[31:12], rd_i, opcode_i};
            FmtJ: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default: instr_o = NopInstr;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder: S1 captures fields plus decoded format and range error,
// S2 holds the packed word. Both stages share one stall enable; words carry a running address.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    inst_encoder_if.slave     bus,
    output logic [7:0]        err_cnt
);

    logic              s1_valid_d, s1_valid_q;
    s1_t               s1_d, s1_q;
    logic              s2_valid_d, s2_valid_q;
    logic [31:0]       s2_instr_d, s2_instr_q;
    logic              s2_err_d, s2_err_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [7:0]        err_cnt_d, err_cnt_q;
    logic [31:0]       packed_instr;
    logic              en;
    logic              out_hs;

    assign en     = !s2_valid_q || bus.out_ready;
    assign out_hs = s2_valid_q && bus.out_ready;

    inst_encoder_imm_pack u_imm_pack (
        .fmt_i    (s1_q.fmt),
        .opcode_i (s1_q.opcode),
        .rd_i     (s1_q.rd),
        .rs1_i    (s1_q.rs1),
        .rs2_i    (s1_q.rs2),
        .funct3_i (s1_q.funct3),
        .funct7_i (s1_q.funct7),
        .imm_i    (s1_q.imm),
        .instr_o  (packed_instr)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        if (en) begin
            s1_valid_d  = bus.in_valid;
            s1_d.fmt    = decode_fmt(bus.opcode);
            s1_d.err    = range_err(s1_d.fmt, bus.imm);
            s1_d.opcode = bus.opcode;
            s1_d.rd     = bus.rd;
            s1_d.rs1    = bus.rs1;
            s1_d.rs2    = bus.rs2;
            s1_d.funct3 = bus.funct3;
            s1_d.funct7 = bus.funct7;
            s1_d.imm    = bus.imm;
            s2_valid_d  = s1_valid_q;
            s2_instr_d  = packed_instr;
            s2_err_d    = s1_q.err;
        end
    end

    // start overrides the handshake increment; the handshaking word already saw the old address.
    always_comb begin
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        if (start) begin
            addr_d    = base_addr;
            err_cnt_d = 8'd0;
        end else if (out_hs) begin
            addr_d = addr_q + ADDR_W'(4);
            if (s2_err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= 32'h0;
            s2_err_q   <= 1'b0;
            addr_q     <= '0;
            err_cnt_q  <= 8'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            addr_q     <= addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_instr = s2_instr_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_err   = s2_err_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Pipelined RV32I instruction encoder: accepts an opcode, register fields, funct fields and a 32-bit immediate, and packs them into a 32-bit instruction word. Immediate bits are scattered per format, the inverse of the ID-stage immediate extraction. Each word is tagged with a sequential byte address. Used by the IMEM preload path and the verification stimulus generator to build program images in-fabric.

## Interface
- `ADDR_W`, default 32: width of the byte-address counter.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset is synchronous and active-low.
- `start` in 1: pulse; loads the address counter from `base_addr` and clears `err_cnt`.
- `base_addr` in ADDR_W: start address; must be word-aligned.
- `in_valid` in 1: request valid.
- `in_ready` out 1: encoder can accept.
- `opcode` in 7: RV32I major opcode; uses the `defines.v` opcode constants.
- `rd`, `rs1`, `rs2` in 5 each: register fields.
- `funct3` in 3, `funct7` in 7: function fields.
- `imm` in 32: immediate as a signed value; the U format takes the final value, e.g. 0x12345000.
- `out_valid` out 1: encoded word valid.
- `out_ready` in 1: consumer accepts.
- `out_instr` out 32: encoded instruction.
- `out_addr` out ADDR_W: byte address of `out_instr`.
- `out_err` out 1: encoding error flag for this word.
- `err_cnt` out 8: saturating count of words emitted with `out_err`=1.

## Operation
- Format is selected by opcode:
  - R: fields only.
  - I (`I_type`, `JALR`, `LOAD`): `imm[11:0]`→[31:20].
  - S: `imm[11:5]`→[31:25], `imm[4:0]`→[11:7].
  - B: `imm[12]`→31, `imm[10:5]`→[30:25], `imm[4:1]`→[11:8], `imm[11]`→7.
  - U (`LUI`, `AUIPC`): `imm[31:12]`→[31:12].
  - J: `imm[20]`→31, `imm[10:1]`→[30:21], `imm[11]`→20, `imm[19:12]`→[19:12].
- Fields unused by the selected format are forced to 0. For example, `funct7` is ignored outside R, and `rd` is ignored for S and B.
- Range check sets `out_err`=1 when any of these hold:
  - I/S: `imm` is not in [-2048, 2047].
  - B: `imm` is not in [-4096, 4094], or `imm[0]`≠0.
  - J: `imm` is not in [-2^20, 2^20-2], or `imm[0]`≠0.
  - U: `imm[11:0]`≠0.
- On a range error the word is still packed from the truncated bits.
- Unknown opcode: `out_err`=1 and `out_instr`=0x00000013 (NOP).
- Address counter:
  - `out_addr` = counter value.
  - The counter increments by 4 on each output handshake (`out_valid` && `out_ready`) and wraps modulo 2^ADDR_W.
- `start` in the same cycle as an output handshake: the handshaking word carries the old address, and the counter loads `base_addr` (start wins over the increment).
- `start` has no effect on words in flight; they take addresses from the reloaded counter.
- `err_cnt` increments on each handshake with `out_err`=1, saturates at 255, and is cleared by `start`. `start` wins over a same-cycle increment.

## Timing
- Two-stage pipeline:
  - S1 registers the inputs, the decoded format and the range-check result.
  - S2 registers the packed word.
- Latency is 2 cycles from input handshake to `out_valid`.
- Throughput is 1 word/cycle.
- Global stall enable: `en` = !S2.valid || `out_ready`; `in_ready` = `en`.
- When `en`=0, both stages hold. `out_instr`, `out_addr` and `out_err` stay stable while `out_valid`=1 and `out_ready`=0.
- Reset values: `out_valid`=0, `in_ready`=1 (combinational after reset), `out_instr`=0, `out_addr`=0 (counter=0), `out_err`=0, `err_cnt`=0, and both stage-valid bits 0.
- Reset mid-operation drops in-flight words, with no output handshake.
- A pipeline bubble (`in_valid`=0 while `en`=1) propagates as an invalid stage.

## Structure
- Format enum (R, I, S, B, U, J, BAD) and the fixed NOP constant belong in a shared package beside the `defines.v` opcodes.
- One natural sub-module, `imm_pack`: combinational (format, fields, imm) → instruction word, with no range checking. It is instantiated in S2.
- Format decode and range check live in S1. The counters and handshake logic live in the top.

## Test plan
- ADDI x1,x0,-1 (opcode 0010011, `rd`=1, `imm`=0xFFFFFFFF) → `out_instr`=0xFFF00093, `out_err`=0, 2 cycles after acceptance.
- SW x2,8(x3) → 0x0021A423. BEQ x0,x0,-4 → 0xFE000EE3. JAL x1,2048 → 0x001000EF. LUI x5,0x12345000 → 0x123452B7.
- ADDI `imm`=2048 → `out_err`=1, `err_cnt`=1. Odd-offset BEQ (`imm`=6+1) → `out_err`=1. Unknown opcode 0x7F → `out_instr`=0x00000013, `out_err`=1.
- `start` with `base_addr`=0x100, then 3 back-to-back words → `out_addr` = 0x100, 0x104, 0x108.
- `out_ready` low for 3 cycles with a word in S2 → outputs stable and `in_ready`=0; then one word per cycle resumes with no loss or duplication.
- `start` asserted in the same cycle as a handshake → that word carries the old address and the next word carries `base_addr`. Reset asserted with 2 words in flight → `out_valid`=0 on the next cycle.
